// File: rtl/axi_master_pkg.sv
// Shared definitions for the AXI burst master: FSM state encoding and the
// fixed AXI attribute values driven on every burst.
package axi_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    AW_W,
    B,
    DONE
  } state_t;

  localparam int AXI_ID_W  = 4;
  localparam int AXI_LEN_W = 8;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD     = 3'b010;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;

endpackage

// File: rtl/axi_interface.sv
// AXI4 channel bundle (32-bit data) shared by the burst master and the
// memory slave model.
interface axi_interface;
  import axi_master_pkg::*;

  logic [AXI_ID_W-1:0]  arid;
  logic [31:0]          araddr;
  logic [AXI_LEN_W-1:0] arlen;
  logic [2:0]           arsize;
  logic [1:0]           arburst;
  logic [3:0]           arcache;
  logic                 arvalid;
  logic                 arready;

  logic [AXI_ID_W-1:0]  rid;
  logic [31:0]          rdata;
  logic [1:0]           rresp;
  logic                 rlast;
  logic                 rvalid;
  logic                 rready;

  logic [AXI_ID_W-1:0]  awid;
  logic [31:0]          awaddr;
  logic [AXI_LEN_W-1:0] awlen;
  logic [2:0]           awsize;
  logic [1:0]           awburst;
  logic [3:0]           awcache;
  logic                 awvalid;
  logic                 awready;

  logic [31:0]          wdata;
  logic [3:0]           wstrb;
  logic                 wlast;
  logic                 wvalid;
  logic                 wready;

  logic [AXI_ID_W-1:0]  bid;
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arcache, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arcache, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master fed by a simple line request
// interface. Optional beat/stall counters under AXI_BURST_MASTER_STATS_EN.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// AR    | read address presented, waiting for arready
// R     | streaming read beats to the consumer until rlast
// AW_W  | write address and write beats in flight independently
// B     | waiting for the write response
// DONE  | one-cycle completion pulse, error status reported
module axi_burst_master
  import axi_master_pkg::*;
#(
  parameter int ID            = 0,
  parameter int MAX_BURST_LEN = 16,
  parameter int LEN_W         = (MAX_BURST_LEN > 1) ? $clog2(MAX_BURST_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_rnw,
  input  logic [31:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_strb,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [31:0]      rd_data,
  output logic             rd_last,
  output logic             done,
  output logic             err,
  axi_interface.master     axi
`ifdef AXI_BURST_MASTER_STATS_EN
  ,
  output logic [31:0]      stat_rd_beats,
  output logic [31:0]      stat_wr_beats,
  output logic [31:0]      stat_stall_cycles
`endif
);

  localparam logic [AXI_ID_W-1:0] ID_V = AXI_ID_W'(ID);

  state_t           state;
  logic [31:0]      addr_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W:0]   cnt;
  logic             err_q;
  logic             aw_done;
  logic             w_done;
  logic             arvalid_q;
  logic             awvalid_q;
  logic             bready_q;
  logic             req_ready_q;
  logic             done_q;
  logic             err_out_q;

  logic cnt_last;
  logic r_hs;
  logic w_hs;
  logic aw_hs;
  logic r_beat_err;
  logic r_len_err;
  logic b_err;

  assign cnt_last   = (cnt == {1'b0, len_q});
  assign r_hs       = (state == R) && axi.rvalid && rd_ready;
  assign w_hs       = axi.wvalid && axi.wready;
  assign aw_hs      = awvalid_q && axi.awready;
  assign r_beat_err = (axi.rresp != AXI_RESP_OKAY) || (axi.rid != ID_V);
  // rlast must coincide with the len-th beat; early or missing rlast both flag
  assign r_len_err  = (axi.rlast != cnt_last);
  assign b_err      = (axi.bresp != AXI_RESP_OKAY) || (axi.bid != ID_V);

  assign axi.arid    = ID_V;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = AXI_LEN_W'(len_q);
  assign axi.arsize  = AXI_SIZE_WORD;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arcache = AXI_CACHE_DEFAULT;
  assign axi.arvalid = arvalid_q;

  assign axi.awid    = ID_V;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = AXI_LEN_W'(len_q);
  assign axi.awsize  = AXI_SIZE_WORD;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awcache = AXI_CACHE_DEFAULT;
  assign axi.awvalid = awvalid_q;

  // Read data passes straight through; rready only follows the consumer in R
  assign axi.rready = (state == R) && rd_ready;
  assign rd_valid   = (state == R) && axi.rvalid;
  assign rd_data    = axi.rdata;
  assign rd_last    = axi.rlast;

  // Write beats stop flowing once the last one has been accepted
  assign axi.wvalid = (state == AW_W) && !w_done && wr_valid;
  assign wr_ready   = (state == AW_W) && !w_done && axi.wready;
  assign axi.wdata  = wr_data;
  assign axi.wstrb  = wr_strb;
  assign axi.wlast  = cnt_last;

  assign axi.bready = bready_q;
  assign req_ready  = req_ready_q;
  assign done       = done_q;
  assign err        = err_out_q;

  // Transaction sequencing with registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      cnt         <= '0;
      err_q       <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      arvalid_q   <= 1'b0;
      awvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      req_ready_q <= 1'b1;
      done_q      <= 1'b0;
      err_out_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            addr_q      <= {req_addr[31:2], 2'b00};
            len_q       <= req_len;
            cnt         <= '0;
            err_q       <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            req_ready_q <= 1'b0;
            if (req_rnw) begin
              state     <= AR;
              arvalid_q <= 1'b1;
            end else begin
              state     <= AW_W;
              awvalid_q <= 1'b1;
            end
          end
        end
        AR: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            state     <= R;
          end
        end
        R: begin
          if (r_hs) begin
            if (!cnt_last) cnt <= cnt + 1'b1;
            if (r_beat_err || r_len_err) err_q <= 1'b1;
            if (axi.rlast) begin
              state     <= DONE;
              done_q    <= 1'b1;
              err_out_q <= err_q || r_beat_err || r_len_err;
            end
          end
        end
        AW_W: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            if (!cnt_last) cnt <= cnt + 1'b1;
            else           w_done <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || (w_hs && cnt_last))) begin
            state    <= B;
            bready_q <= 1'b1;
          end
        end
        B: begin
          if (axi.bvalid) begin
            bready_q  <= 1'b0;
            state     <= DONE;
            done_q    <= 1'b1;
            err_out_q <= err_q || b_err;
          end
        end
        DONE: begin
          done_q      <= 1'b0;
          err_out_q   <= 1'b0;
          err_q       <= 1'b0;
          cnt         <= '0;
          aw_done     <= 1'b0;
          w_done      <= 1'b0;
          req_ready_q <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXI_BURST_MASTER_STATS_EN
  logic stall;
  assign stall = (arvalid_q && !axi.arready) || (awvalid_q && !axi.awready) ||
                 (axi.wvalid && !axi.wready);

  // Free-running beat and stall counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_rd_beats     <= '0;
      stat_wr_beats     <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (r_hs)  stat_rd_beats     <= stat_rd_beats + 32'd1;
      if (w_hs)  stat_wr_beats     <= stat_wr_beats + 32'd1;
      if (stall) stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- AXI4 master that turns a simple single-request line interface (cache fill / writeback, DMA-style) into AXI INCR bursts of 32-bit beats.
- Sits between an L1/L2 miss handler and the system AXI bus. It is the initiator counterpart to the simulated AXI memory slave used in test benches.
- One transaction outstanding at a time: read (AR/R) or write (AW/W/B).

Parameters:
- ID, 0, value driven on arid/awid; also the expected rid/bid.
- MAX_BURST_LEN, 16, maximum beats per burst (power of two, 1..256).
- LEN_W, $clog2(MAX_BURST_LEN) (min 1), width of req_len.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low (0 = reset)
- req_valid  input  1  request valid
- req_ready  output  1  request accepted when req_valid & req_ready
- req_rnw  input  1  1 = read, 0 = write
- req_addr  input  32  byte address; bits [1:0] ignored and driven 0
- req_len  input  LEN_W  beats minus one
- wr_valid  input  1  write data beat valid
- wr_ready  output  1  write data beat consumed
- wr_data  input  32  write data
- wr_strb  input  4  byte enables
- rd_valid  output  1  read beat valid
- rd_ready  input  1  consumer ready; drives rready
- rd_data  output  32  read beat data
- rd_last  output  1  final beat of burst
- done  output  1  one-cycle pulse at transaction completion
- err  output  1  valid with done; 1 = non-OKAY resp or ID mismatch seen
- axi  axi_interface.master  -  AXI4 master port (ar*, r*, aw*, w*, b*)

Behaviour:
- Reset (rst=0 at clk edge): state IDLE. Same edge forces arvalid=awvalid=wvalid=0, bready=0, rready=0, done=0, err=0, req_ready=1 (after reset), beat counter=0, error flag=0.
- Reset mid-burst abandons the transaction; no completion pulse.
- Constant AXI fields: arsize/awsize=3'b010, arburst/awburst=2'b01 (INCR), arcache/awcache=4'b0011, arlen/awlen = zero-extended req_len.
- FSM states: IDLE, AR, R, AW_W, B, DONE.
- IDLE: req_ready=1. On handshake, latch addr/len/rnw and go to AR (read) or AW_W (write). arvalid/awvalid rise the next cycle (registered, 1-cycle latency).
- AR: arvalid held with stable fields until arready. Then go to R.
- R: rready = rd_ready. rd_valid/rd_data/rd_last are combinational pass-through of rvalid/rdata/rlast. Each beat handshake increments the counter.
  - Exit to DONE on a handshake with rlast=1.
  - If counter reaches len before rlast, or rlast arrives early, set the error flag; completion still waits for rlast.
- AW_W: awvalid held until awready, with an independent aw_done flag. In parallel: wvalid = wr_valid, wr_ready = wready, wdata/wstrb pass through, wlast = (counter == len).
  - W beats may complete before AW.
  - Go to B when aw_done and the last W beat are both handshaken, including when both occur in the same cycle.
- B: bready=1. On bvalid go to DONE.
- Error flag is set by rresp/bresp != 0 or rid/bid != ID.
- DONE: done=1 and err=error flag for exactly one cycle. Error flag and counter clear. Return to IDLE; req_ready=0 during DONE.
- Back-to-back requests: minimum gap one cycle (DONE) plus one IDLE cycle.
- req_len=0: single beat; rlast/wlast on first beat.
- Counter wraps never: width LEN_W+1 with saturation at len.

Optional Feature:
- Macro AXI_BURST_MASTER_STATS_EN.
- Defined: adds outputs stat_rd_beats[31:0], stat_wr_beats[31:0], stat_stall_cycles[31:0], reset to 0.
  - stat_rd_beats counts R handshakes; stat_wr_beats counts W handshakes.
  - stat_stall_cycles counts cycles with any of arvalid&!arready, awvalid&!awready, wvalid&!wready.
  - All counters wrap modulo 2^32.
- Undefined: ports and logic absent; functional behaviour identical.

Decomposition:
- Shared package axi_master_pkg: state enum (IDLE, AR, R, AW_W, B, DONE); constants AXI_BURST_INCR, AXI_SIZE_WORD, AXI_CACHE_DEFAULT, AXI_RESP_OKAY.
- No sub-module; the stats counters sit in a generate-free `ifdef block in the same module.

Test Plan:
- Read req addr=0x8000_0010, len=3, slave returns 0x11,0x22,0x33,0x44 -> arlen=3, araddr=0x8000_0010; rd_data in order, rd_last on 4th beat; done=1, err=0 one cycle after.
- Write req addr=0x100, len=1, data 0xAAAA_5555 strb=0xF then 0x1234_5678 strb=0x3 -> awlen=1; wlast only on beat 2; memory 0x100=0xAAAA5555, 0x104 low half=0x5678; done after bvalid, err=0.
- Write with awready held low 10 cycles while both W beats accepted first -> no B wait until AW handshake; exactly one done.
- Read with rd_ready toggling 1/0 each cycle, len=7 -> rready mirrors rd_ready, 8 beats, no data loss or duplication.
- Read where slave returns rresp=2'b10 on beat 2 of len=3 -> all 4 beats delivered; done with err=1; next clean read gives err=0.
- rst driven 0 during beat 2 of a len=7 read -> next edge: rready=0, arvalid=0, done=0, req_ready=1 after release; new read completes normally.
